// File: rtl/shift_pkg.sv
// Shared mode encoding and stage-partitioning helpers for the pipelined barrel shifter.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] SHIFT_SLL = 3'd0;
  localparam logic [MODE_W-1:0] SHIFT_SRL = 3'd1;
  localparam logic [MODE_W-1:0] SHIFT_SRA = 3'd2;
  localparam logic [MODE_W-1:0] SHIFT_ROL = 3'd3;
  localparam logic [MODE_W-1:0] SHIFT_ROR = 3'd4;

  function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
    return mode <= SHIFT_ROR;
  endfunction

  // The first (levels % stages) stages each take one extra mux level.
  function automatic int unsigned stage_levels(input int unsigned levels,
                                               input int unsigned stages,
                                               input int unsigned s);
    return (levels / stages) + ((s < (levels % stages)) ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned stage_first(input int unsigned levels,
                                              input int unsigned stages,
                                              input int unsigned s);
    return s * (levels / stages) + ((s < (levels % stages)) ? s : (levels % stages));
  endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational barrel-shifter level: shifts or rotates by AMT when enabled.
module shift_level
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT   = 1
) (
  input  logic [WIDTH-1:0]  data,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  result
);

  always_comb begin
    result = data;
    if (en) begin
      case (mode)
        SHIFT_SLL: result = data << AMT;
        SHIFT_SRL: result = data >> AMT;
        SHIFT_SRA: result = WIDTH'($signed(data) >>> AMT);
        SHIFT_ROL: result = (data << AMT) | (data >> (WIDTH - AMT));
        SHIFT_ROR: result = (data >> AMT) | (data << (WIDTH - AMT));
        default:   result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) shift levels split over PIPE_STAGES register stages
// behind a valid/ready handshake, carrying a writeback tag and an illegal-mode flag.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter  int unsigned WIDTH       = 32,
  parameter  int unsigned PIPE_STAGES = 2,
  parameter  int unsigned TAG_W       = 5,
  localparam int unsigned SHAMT_W     = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [MODE_W-1:0]  in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam int unsigned LEVELS = SHAMT_W;

  // sin_* is the input side of each stage, *_q its register.
  logic [WIDTH-1:0]   sin_data  [PIPE_STAGES];
  logic [SHAMT_W-1:0] sin_shamt [PIPE_STAGES];
  logic [MODE_W-1:0]  sin_mode  [PIPE_STAGES];
  logic [TAG_W-1:0]   sin_tag   [PIPE_STAGES];
  logic               sin_err   [PIPE_STAGES];
  logic               sin_valid [PIPE_STAGES];

  logic [WIDTH-1:0]   data_q    [PIPE_STAGES];
  logic [SHAMT_W-1:0] shamt_q   [PIPE_STAGES];
  logic [MODE_W-1:0]  mode_q    [PIPE_STAGES];
  logic [TAG_W-1:0]   tag_q     [PIPE_STAGES];
  logic               err_q     [PIPE_STAGES];
  logic               valid_q   [PIPE_STAGES];

  logic               can_load  [PIPE_STAGES];
  logic               drain;

  // A stage may capture when it is empty or its content moves on this cycle.
  always_comb begin
    drain = out_ready;
    for (int s = int'(PIPE_STAGES) - 1; s >= 0; s--) begin
      drain       = drain | !valid_q[s];
      can_load[s] = drain;
    end
  end

  assign in_ready = can_load[0] & reset;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int unsigned First = stage_first(LEVELS, PIPE_STAGES, s);
    localparam int unsigned Nl    = stage_levels(LEVELS, PIPE_STAGES, s);

    logic [WIDTH-1:0] chain [Nl+1];

    if (s == 0) begin : g_in
      assign sin_valid[s] = in_valid;
      assign sin_data[s]  = in_data;
      assign sin_shamt[s] = in_shamt;
      assign sin_mode[s]  = in_mode;
      assign sin_tag[s]   = in_tag;
      assign sin_err[s]   = !is_legal_mode(in_mode);
    end else begin : g_link
      assign sin_valid[s] = valid_q[s-1];
      assign sin_data[s]  = data_q[s-1];
      assign sin_shamt[s] = shamt_q[s-1];
      assign sin_mode[s]  = mode_q[s-1];
      assign sin_tag[s]   = tag_q[s-1];
      assign sin_err[s]   = err_q[s-1];
    end

    assign chain[0] = sin_data[s];

    for (genvar j = 0; j < Nl; j++) begin : g_level
      shift_level #(
        .WIDTH (WIDTH),
        .AMT   (1 << (First + j))
      ) u_level (
        .data   (chain[j]),
        .en     (sin_shamt[s][First+j]),
        .mode   (sin_mode[s]),
        .result (chain[j+1])
      );
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        mode_q[s]  <= '0;
        tag_q[s]   <= '0;
        err_q[s]   <= 1'b0;
      end else if (can_load[s]) begin
        valid_q[s] <= sin_valid[s];
        if (sin_valid[s]) begin
          data_q[s]  <= chain[Nl];
          shamt_q[s] <= sin_shamt[s];
          mode_q[s]  <= sin_mode[s];
          tag_q[s]   <= sin_tag[s];
          err_q[s]   <= sin_err[s];
        end
      end
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign out_data  = data_q[PIPE_STAGES-1];
  assign out_tag   = tag_q[PIPE_STAGES-1];
  assign out_err   = err_q[PIPE_STAGES-1];

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, pipelined barrel shifter for the processor ALU path.
- Successor to the single-cycle combinational arithmetic right shifter; covers SLL, SRL, SRA, ROL and ROR at configurable width.
- Spreads the log2(WIDTH) mux levels over PIPE_STAGES register stages, behind a valid/ready handshake.
- Carries a destination tag for writeback.

Parameters:
- WIDTH, 32: operand/result width; power of two, 8..64.
- PIPE_STAGES, 2: register stages, 1..log2(WIDTH); equals latency in cycles.
- TAG_W, 5: width of the passthrough tag (destination register index).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid & in_ready.
- in_data  in  WIDTH  operand.
- in_shamt  in  log2(WIDTH)  shift amount.
- in_mode  in  3  operation code (see package).
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  illegal mode code for this result.

Behaviour:
- Modes:
  - SLL=0: zero fill from LSB.
  - SRL=1: zero fill from MSB.
  - SRA=2: fill with in_data[WIDTH-1].
  - ROL=3, ROR=4: bits wrap around.
  - Codes 5..7 are illegal: data passes unshifted, out_err=1.
- in_shamt is taken modulo WIDTH by port width; shamt=0 returns in_data unchanged in every mode.
- Level k shifts by 2^k, k=0..log2(WIDTH)-1, applied in ascending order.
- Stage s executes a contiguous group of levels. The first (L mod PIPE_STAGES) stages take one extra level (L=log2 WIDTH).
  - Example: WIDTH=32, PIPE_STAGES=2 gives stage0 = levels 0-2, stage1 = levels 3-4.
  - Each stage ends in a register holding partial data, remaining shamt bits, mode, tag, err and a valid bit.
- Latency: a request accepted at edge N appears on out_* after edge N+PIPE_STAGES, provided no stall.
- Throughput: one result per cycle while out_ready=1.
- Stall (per-stage advance):
  - Last stage advances when out_ready | !out_valid.
  - Stage s advances when stage s+1 advances or is empty.
  - in_ready = stage0 advances or stage0 is empty. This is combinational from out_ready; no skid buffer.
- Hold: while out_valid=1 and out_ready=0, out_data, out_tag and out_err stay stable. Upstream stages hold their contents, so no bubble is lost and no data is overwritten.
- Simultaneous accept and drain with the pipeline full: allowed; occupancy stays the same.
- Bubbles: an empty stage may be filled while a later stage stalls. Stages compress toward the output.
- Reset (reset=0, asynchronous, any time including mid-operation):
  - All valid bits clear immediately.
  - out_valid=0, out_data=0, out_tag=0, out_err=0.
  - in_ready=0 while reset is low; in_ready=1 from the first cycle after release.
  - In-flight requests are discarded.
- Only the valid bits require reset; data registers are reset for deterministic debug.
- No combinational path from in_* to out_*, for any PIPE_STAGES >= 1.

Decomposition:
- Package shift_pkg: mode localparams SHIFT_SLL..SHIFT_ROR, MODE_W=3, function is_legal_mode.
- Sub-module shift_level: a single combinational level, parameter AMT=2^k. Inputs: data, enable bit, mode. Output: shifted data.
- The top instantiates log2(WIDTH) shift_level blocks via generate and inserts stage registers at the group boundaries.

Test Plan:
- Walking shift, WIDTH=32, PIPE_STAGES=2, SRA, data=0x80000001, shamt 0..31, out_ready=1:
  - shamt=0 gives 0x80000001; shamt=4 gives 0xF8000000; shamt=31 gives 0xFFFFFFFF.
  - Each result appears exactly 2 cycles after accept.
- All modes, data=0x12345678, shamt=8:
  - SLL=0x34567800, SRL=0x00123456, SRA=0x00123456, ROL=0x34567812, ROR=0x78123456.
  - Mode 6 gives 0x12345678 with out_err=1.
- Back-pressure: 5 back-to-back requests with tags 1..5, out_ready low for cycles 3..6.
  - in_ready drops once the pipeline is full.
  - Tags emerge in order 1..5 with no loss or duplication.
  - out_data stays stable during the stall.
- Reset mid-flight: 2 requests in the pipeline, then reset low for 1 cycle.
  - out_valid=0 immediately and out_data=0.
  - Neither request ever emerges; in_ready=1 the cycle after release.
- Parameter sweep: WIDTH=8/PIPE_STAGES=3 and WIDTH=64/PIPE_STAGES=1, random stimulus against a reference model.
  - Latency equals PIPE_STAGES; zero mismatches over 10k requests.
- Simultaneous events: pipeline full with out_ready=1 and in_valid=1 every cycle for 20 cycles.
  - One result per cycle; in_ready stays high throughout.
